wb_write_arbiter: RTL and testbench

//  Drives the single write port of the register file (writereg/writeData/writeEn) from two writeback sources.

---
 rtl/wb_write_arbiter_pkg.sv | 26 ++
 rtl/wb_write_arbiter_fifo.sv | 87 ++++++++
 rtl/wb_write_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_write_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, FIFO entry layout and selection encoding for the writeback arbiter.
package wb_write_arbiter_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int REG_FILE_SIZE     = 32;
    localparam int WB_FIFO_DEPTH     = 2;
    localparam int WB_STARVE_LIMIT   = 4;

    typedef logic [REG_FILE_ADDR_LEN-1:0] reg_addr_t;
    typedef logic [WORD_LEN-1:0]          word_t;

    typedef struct packed {
        logic      killed;
        reg_addr_t rd;
        word_t     data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE   = 2'd0,
        SEL_PIPE   = 2'd1,
        SEL_DRAIN  = 2'd2,
        SEL_STARVE = 2'd3
    } wb_sel_e;

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// Circular buffer of mdu results {killed, rd, data} with a kill port for WAW squashing.
// With WB_SCOREBOARD_EN the per-entry live/dest view is exported for the busy mask.
module wb_write_arbiter_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  reg_addr_t              push_reg,
    input  word_t                  push_data,
    input  logic                   pop,
    input  logic                   kill_en,
    input  reg_addr_t              kill_reg,
`ifdef WB_SCOREBOARD_EN
    output logic [DEPTH-1:0]       live,
    output reg_addr_t [DEPTH-1:0]  ent_reg,
`endif
    output wb_entry_t              head,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [DEPTH-1:0] occupied;

    // A slot is occupied when its distance from the read pointer is below the count.
    always_comb begin
        occupied = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = CW'(AW'(AW'(i) - rd_ptr)) < count;
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

`ifdef WB_SCOREBOARD_EN
    always_comb begin
        live    = '0;
        ent_reg = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i]    = occupied[i] & ~mem[i].killed;
            ent_reg[i] = mem[i].rd;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && occupied[i] && (mem[i].rd == kill_reg)) begin
                    mem[i].killed <= 1'b1;
                end
            end
            // Push only targets a free slot, so it never collides with a kill.
            if (push) begin
                mem[wr_ptr] <= '{killed: 1'b0, rd: push_reg, data: push_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline WB has priority, mdu results are buffered
// and forced through by a starve counter. WB_SCOREBOARD_EN enables the busy_mask decode.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pipe_we,
    input  reg_addr_t                pipe_reg,
    input  word_t                    pipe_data,
    output logic                     pipe_stall,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  reg_addr_t                mdu_reg,
    input  word_t                    mdu_data,
    output logic                     wb_en,
    output reg_addr_t                wb_reg,
    output word_t                    wb_data,
    output logic [REG_FILE_SIZE-1:0] busy_mask
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;
    logic      kill_en;
    logic      issue;
    reg_addr_t issue_reg;
    word_t     issue_data;
    wb_sel_e   sel;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;

`ifdef WB_SCOREBOARD_EN
    logic [FIFO_DEPTH-1:0]      live;
    reg_addr_t [FIFO_DEPTH-1:0] ent_reg;
`endif

    // Ready reflects start-of-cycle occupancy; a pop never opens the slot early.
    assign mdu_ready  = rst & ~full;
    assign push       = mdu_valid & mdu_ready & (mdu_reg != '0);
    assign pipe_stall = (sel == SEL_STARVE);

    wb_write_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_reg  (mdu_reg),
        .push_data (mdu_data),
        .pop       (pop),
        .kill_en   (kill_en),
        .kill_reg  (pipe_reg),
`ifdef WB_SCOREBOARD_EN
        .live      (live),
        .ent_reg   (ent_reg),
`endif
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        sel        = SEL_IDLE;
        pop        = 1'b0;
        kill_en    = 1'b0;
        issue      = 1'b0;
        issue_reg  = head.rd;
        issue_data = head.data;
        starve_nxt = '0;
        if (!empty && (starve_cnt == SW'(STARVE_LIMIT))) begin
            sel = SEL_STARVE;
        end else if (pipe_we && (pipe_reg != '0)) begin
            sel = SEL_PIPE;
        end else if (!empty) begin
            sel = SEL_DRAIN;
        end
        case (sel)
            SEL_STARVE, SEL_DRAIN: begin
                // A killed head is consumed without a register write.
                pop   = 1'b1;
                issue = ~head.killed;
            end
            SEL_PIPE: begin
                issue      = 1'b1;
                kill_en    = 1'b1;
                issue_reg  = pipe_reg;
                issue_data = pipe_data;
                starve_nxt = empty ? '0 : starve_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en      <= 1'b0;
            wb_reg     <= '0;
            wb_data    <= '0;
            starve_cnt <= '0;
        end else begin
            wb_en      <= issue;
            starve_cnt <= starve_nxt;
            if (issue) begin
                wb_reg  <= issue_reg;
                wb_data <= issue_data;
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    // Entries being killed by this cycle's pipe write are already excluded.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live[i] && !(kill_en && (ent_reg[i] == pipe_reg))) begin
                busy_mask[ent_reg[i]] = 1'b1;
            end
        end
        busy_mask[0] = 1'b0;
    end
`else
    assign busy_mask = '0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue model.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_we = 1'b0;
    reg_addr_t   pipe_reg = '0;
    word_t       pipe_data = '0;
    logic        pipe_stall;
    logic        mdu_valid = 1'b0;
    logic        mdu_ready;
    reg_addr_t   mdu_reg = '0;
    word_t       mdu_data = '0;
    logic        wb_en;
    reg_addr_t   wb_reg;
    word_t       wb_data;
    logic [31:0] busy_mask;

    int total = 0;
    int bad   = 0;

    logic        s_ready, s_stall, s_en;
    reg_addr_t   s_reg;
    word_t       s_data;
    logic [31:0] s_busy;

    wb_entry_t   mq[$];
    int          m_starve;
    logic        m_en;
    reg_addr_t   m_reg;
    word_t       m_data;

    wb_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_we    (pipe_we),
        .pipe_reg   (pipe_reg),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_reg    (mdu_reg),
        .mdu_data   (mdu_data),
        .wb_en      (wb_en),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data),
        .busy_mask  (busy_mask)
    );

    always #5 clk = ~clk;

    // Expected busy_mask for the current build: the live set, or zero when the feature is off.
    function automatic logic [31:0] sb(input logic [31:0] m);
`ifdef WB_SCOREBOARD_EN
        return m;
`else
        return 32'h0 & m;
`endif
    endfunction

    // One cycle: drive at negedge, sample combinational outputs, then registered outputs after posedge.
    task automatic drive(input logic pwe, input reg_addr_t preg, input word_t pdata,
                         input logic mv, input reg_addr_t mreg, input word_t mdata);
        @(negedge clk);
        pipe_we = pwe; pipe_reg = preg; pipe_data = pdata;
        mdu_valid = mv; mdu_reg = mreg; mdu_data = mdata;
        #1;
        s_ready = mdu_ready; s_stall = pipe_stall; s_busy = busy_mask;
        @(posedge clk);
        #1;
        s_en = wb_en; s_reg = wb_reg; s_data = wb_data;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        pipe_we = 1'b0; mdu_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_wb_en got=%0b exp=0", wb_en); end
        total++; if (wb_reg !== 5'd0) begin bad++; $display("FAIL rst_wb_reg got=%0d exp=0", wb_reg); end
        total++; if (wb_data !== 32'd0) begin bad++; $display("FAIL rst_wb_data got=%h exp=0", wb_data); end
        total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", pipe_stall); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", mdu_ready); end
        total++; if (busy_mask !== 32'd0) begin bad++; $display("FAIL rst_busy got=%h exp=0", busy_mask); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_pipe_only();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL pipe_stall got=%0b exp=0", s_stall); end
        total++; if (s_en !== 1'b1) begin bad++; $display("FAIL pipe_en got=%0b exp=1", s_en); end
        total++; if (s_reg !== 5'd5) begin bad++; $display("FAIL pipe_reg got=%0d exp=5", s_reg); end
        total++; if (s_data !== 32'hDEADBEEF) begin bad++; $display("FAIL pipe_data got=%h exp=deadbeef", s_data); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL pipe_idle_en got=%0b exp=0", s_en); end
        total++; if (s_reg !== 5'd5) begin bad++; $display("FAIL pipe_hold_reg got=%0d exp=5", s_reg); end
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd0, 32'h123, 1'b0, '0, '0);
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL r0_pipe_en got=%0b exp=0", s_en); end
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h55);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL r0_mdu_ready got=%0b exp=1", s_ready); end
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL r0_mdu_en got=%0b exp=0", s_en); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL r0_after_en got=%0b exp=0", s_en); end
        total++; if (s_busy !== 32'd0) begin bad++; $display("FAIL r0_busy got=%h exp=0", s_busy); end
    endtask

    task automatic test_backpressure();
        reg_addr_t mr = 5'd1;
        logic [5:0] exp_rdy = 6'b000011;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, reg_addr_t'(10 + c), word_t'(100 + c), 1'b1, mr, word_t'(32'hA0 + mr));
            total++; if (s_ready !== exp_rdy[c]) begin bad++; $display("FAIL bp_ready c=%0d got=%0b exp=%0b", c, s_ready, exp_rdy[c]); end
            if (s_ready) mr = mr + 5'd1;
            total++; if (s_stall !== (c == 5)) begin bad++; $display("FAIL bp_stall c=%0d got=%0b exp=%0b", c, s_stall, c == 5); end
            total++; if (s_en !== 1'b1) begin bad++; $display("FAIL bp_en c=%0d got=%0b exp=1", c, s_en); end
            total++; if (s_reg !== ((c == 5) ? 5'd1 : reg_addr_t'(10 + c))) begin bad++; $display("FAIL bp_reg c=%0d got=%0d", c, s_reg); end
            total++; if (s_data !== ((c == 5) ? 32'hA1 : word_t'(100 + c))) begin bad++; $display("FAIL bp_data c=%0d got=%h", c, s_data); end
            if (c == 2) begin
                total++; if (s_busy !== sb(32'h6)) begin bad++; $display("FAIL bp_busy got=%h exp=%h", s_busy, sb(32'h6)); end
            end
        end
        drive(1'b1, 5'd16, 32'd106, 1'b1, mr, word_t'(32'hA0 + mr));
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen_ready got=%0b exp=1", s_ready); end
        total++; if (s_stall !== 1'b0) begin bad++; $display("FAIL bp_reopen_stall got=%0b exp=0", s_stall); end
        total++; if (s_reg !== 5'd16) begin bad++; $display("FAIL bp_reopen_reg got=%0d exp=16", s_reg); end
        idle();
        total++; if (s_en !== 1'b1 || s_reg !== 5'd2 || s_data !== 32'hA2) begin bad++; $display("FAIL bp_drain2 got en=%0b reg=%0d data=%h exp 1/2/a2", s_en, s_reg, s_data); end
        idle();
        total++; if (s_en !== 1'b1 || s_reg !== 5'd3 || s_data !== 32'hA3) begin bad++; $display("FAIL bp_drain3 got en=%0b reg=%0d data=%h exp 1/3/a3", s_en, s_reg, s_data); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL bp_empty_en got=%0b exp=0", s_en); end
    endtask

    task automatic test_waw();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h11);
        total++; if (s_ready !== 1'b1 || s_en !== 1'b0) begin bad++; $display("FAIL waw_push got ready=%0b en=%0b exp 1/0", s_ready, s_en); end
        drive(1'b1, 5'd9, 32'h99, 1'b0, '0, '0);
        total++; if (s_busy !== sb(32'h80)) begin bad++; $display("FAIL waw_busy_set got=%h exp=%h", s_busy, sb(32'h80)); end
        total++; if (s_en !== 1'b1 || s_reg !== 5'd9) begin bad++; $display("FAIL waw_other got en=%0b reg=%0d exp 1/9", s_en, s_reg); end
        drive(1'b1, 5'd7, 32'h22, 1'b0, '0, '0);
        total++; if (s_busy !== 32'd0) begin bad++; $display("FAIL waw_busy_clr got=%h exp=0", s_busy); end
        total++; if (s_en !== 1'b1 || s_data !== 32'h22) begin bad++; $display("FAIL waw_pipe got en=%0b data=%h exp 1/22", s_en, s_data); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL waw_killed_en got=%0b exp=0", s_en); end
        total++; if (s_reg !== 5'd7 || s_data !== 32'h22) begin bad++; $display("FAIL waw_hold got reg=%0d data=%h exp 7/22", s_reg, s_data); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL waw_after_en got=%0b exp=0", s_en); end
    endtask

    task automatic test_idle_drain();
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd12, 32'hC12);
        drive(1'b1, 5'd21, 32'h201, 1'b1, 5'd13, 32'hC13);
        total++; if (s_en !== 1'b1 || s_reg !== 5'd21) begin bad++; $display("FAIL drain_fill got en=%0b reg=%0d exp 1/21", s_en, s_reg); end
        idle();
        total++; if (s_en !== 1'b1 || s_reg !== 5'd12 || s_data !== 32'hC12) begin bad++; $display("FAIL drain_first got en=%0b reg=%0d data=%h", s_en, s_reg, s_data); end
        idle();
        total++; if (s_en !== 1'b1 || s_reg !== 5'd13 || s_data !== 32'hC13) begin bad++; $display("FAIL drain_second got en=%0b reg=%0d data=%h", s_en, s_reg, s_data); end
        idle();
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL drain_done got=%0b exp=0", s_en); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd20, 32'h300, 1'b1, 5'd14, 32'hE14);
        drive(1'b1, 5'd21, 32'h301, 1'b1, 5'd15, 32'hE15);
        @(negedge clk);
        pipe_we = 1'b0; mdu_valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (wb_en !== 1'b0 || wb_reg !== 5'd0 || wb_data !== 32'd0) begin bad++; $display("FAIL midrst_wb got en=%0b reg=%0d data=%h exp 0", wb_en, wb_reg, wb_data); end
        total++; if (mdu_ready !== 1'b0 || pipe_stall !== 1'b0 || busy_mask !== 32'd0) begin bad++; $display("FAIL midrst_ctl got ready=%0b stall=%0b busy=%h exp 0", mdu_ready, pipe_stall, busy_mask); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idle();
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready c=%0d got=%0b exp=1", c, s_ready); end
            total++; if (s_en !== 1'b0) begin bad++; $display("FAIL midrst_stale c=%0d got=%0b exp=0", c, s_en); end
        end
    endtask

    task automatic test_random();
        logic pwe = 1'b0, mv = 1'b0, hold_pipe = 1'b0, hold_mdu = 1'b0;
        reg_addr_t preg = '0, mreg = '0, i_reg;
        word_t pdata = '0, mdata = '0, i_data;
        logic e_ready, e_stall, pkill, issue;
        logic [31:0] e_busy;
        wb_entry_t hd;
        apply_reset();
        mq.delete(); m_starve = 0; m_en = 1'b0; m_reg = '0; m_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_pipe) begin pwe = ($urandom_range(0, 9) < 6); preg = reg_addr_t'($urandom_range(0, 7)); pdata = $urandom; end
            if (!hold_mdu) begin mv = ($urandom_range(0, 9) < 4); mreg = reg_addr_t'($urandom_range(0, 7)); mdata = $urandom; end
            e_ready = (mq.size() < DEPTH);
            e_stall = (mq.size() > 0) && (m_starve == LIMIT);
            pkill   = !e_stall && pwe && (preg != 0);
            e_busy  = '0;
            for (int k = 0; k < mq.size(); k++)
                if (!mq[k].killed && !(pkill && mq[k].rd == preg)) e_busy[mq[k].rd] = 1'b1;
            e_busy[0] = 1'b0;
            e_busy = sb(e_busy);
            issue = 1'b0; i_reg = '0; i_data = '0;
            if (e_stall || (!pkill && mq.size() > 0)) begin
                hd = mq.pop_front();
                issue = !hd.killed; i_reg = hd.rd; i_data = hd.data;
                m_starve = 0;
            end else if (pkill) begin
                issue = 1'b1; i_reg = preg; i_data = pdata;
                for (int k = 0; k < mq.size(); k++)
                    if (mq[k].rd == preg) mq[k].killed = 1'b1;
                m_starve = (mq.size() > 0) ? m_starve + 1 : 0;
            end else begin
                m_starve = 0;
            end
            if (e_ready && mv && mreg != 0) mq.push_back('{killed: 1'b0, rd: mreg, data: mdata});
            if (issue) begin m_en = 1'b1; m_reg = i_reg; m_data = i_data; end
            else m_en = 1'b0;
            drive(pwe, preg, pdata, mv, mreg, mdata);
            total++; if (s_ready !== e_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, s_ready, e_ready); end
            total++; if (s_stall !== e_stall) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", c, s_stall, e_stall); end
            total++; if (s_busy !== e_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%h exp=%h", c, s_busy, e_busy); end
            total++; if (s_en !== m_en || s_reg !== m_reg || s_data !== m_data) begin bad++; $display("FAIL rnd_wb c=%0d got en=%0b reg=%0d data=%h exp en=%0b reg=%0d data=%h", c, s_en, s_reg, s_data, m_en, m_reg, m_data); end
            hold_pipe = s_stall && pwe;
            hold_mdu  = mv && !s_ready;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_pipe_only();
        test_r0();
        test_backpressure();
        test_waw();
        test_idle_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
